// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and BRAM write ports of the program loader.
//   in_dat/in_valid/in_ready : byte stream, transfer on in_valid && in_ready
//   i_w_addr/i_w_dat/i_w_enb : instruction BRAM write port
//   d_w_addr/d_w_dat/d_w_enb : data BRAM write port
// Modports:
//   slave  - the loader (consumes the stream, drives the BRAM ports)
//   master - the stream source / BRAM side
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_dat;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] i_w_addr;
  logic [31:0]           i_w_dat;
  logic                  i_w_enb;
  logic [ADDR_WIDTH-1:0] d_w_addr;
  logic [31:0]           d_w_dat;
  logic                  d_w_enb;

  modport slave (
    input  in_dat, in_valid,
    output in_ready,
    output i_w_addr, i_w_dat, i_w_enb,
    output d_w_addr, d_w_dat, d_w_enb
  );

  modport master (
    output in_dat, in_valid,
    input  in_ready,
    input  i_w_addr, i_w_dat, i_w_enb,
    input  d_w_addr, d_w_dat, d_w_enb
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the instruction/data BRAMs of the
// RV32I core. Frames: 'I'/'D' LEN_LO LEN_HI payload(N words, LSB first) CSUM,
// or 'G' to release the core. Assembles little-endian words and issues one
// registered write strobe per word.
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   bus               stream input and both BRAM write ports (slave modport)
//   d_bram_init_done  data BRAM handed to the core (RUN)
//   pc_stall          holds the core PC until RUN
//   busy              segment in progress (LEN_LO..CSUM)
//   err               sticky protocol error (ERROR)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_CMD    | waiting for command byte 'I', 'D' or 'G'
// S_LEN_LO | waiting for low byte of word count
// S_LEN_HI | waiting for high byte of word count, range check
// S_DATA   | collecting payload bytes, one BRAM write per 4 bytes
// S_CSUM   | comparing checksum byte against XOR of payload
// S_RUN    | core released, stream ignored until reset
// S_ERROR  | protocol error, stream ignored until reset
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus,
  output logic          d_bram_init_done,
  output logic          pc_stall,
  output logic          busy,
  output logic          err
);

  localparam int         WIDX_W = ADDR_WIDTH - 2;
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  localparam logic [7:0] CMD_I  = 8'h49;
  localparam logic [7:0] CMD_D  = 8'h44;
  localparam logic [7:0] CMD_G  = 8'h47;

  typedef enum logic [2:0] {
    S_CMD,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic              in_ready_int;
  logic              accept;
  logic              target_d;
  logic [7:0]        len_lo;
  logic [15:0]       n_words;
  logic [WIDX_W-1:0] len_m1;
  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sh;
  logic [7:0]        csum;
  logic              last_byte;
  logic              last_word;

  logic [ADDR_WIDTH-1:0] i_w_addr_r, d_w_addr_r;
  logic [31:0]           i_w_dat_r, d_w_dat_r;
  logic                  i_w_enb_r, d_w_enb_r;

  // Ready is forced low while reset is asserted, not only after it.
  assign in_ready_int = rst && (state != S_RUN) && (state != S_ERROR);
  assign accept       = bus.in_valid && in_ready_int;
  assign n_words      = {bus.in_dat, len_lo};
  assign last_byte    = (byte_idx == 2'd3);
  assign last_word    = (word_idx == len_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CMD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_CMD: begin
          if (bus.in_dat == CMD_I || bus.in_dat == CMD_D) begin
            state_nxt = S_LEN_LO;
          end else if (bus.in_dat == CMD_G) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_ERROR;
          end
        end
        S_LEN_LO: state_nxt = S_LEN_HI;
        S_LEN_HI: begin
          if (n_words > MAX_N) begin
            state_nxt = S_ERROR;
          end else if (n_words == 16'd0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (last_byte && last_word) begin
            state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (bus.in_dat == csum) begin
            state_nxt = S_CMD;
          end else begin
            state_nxt = S_ERROR;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_d   <= 1'b0;
      len_lo     <= 8'h00;
      len_m1     <= '0;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      word_sh    <= 24'h0;
      csum       <= 8'h00;
      i_w_addr_r <= '0;
      i_w_dat_r  <= 32'h0;
      i_w_enb_r  <= 1'b0;
      d_w_addr_r <= '0;
      d_w_dat_r  <= 32'h0;
      d_w_enb_r  <= 1'b0;
    end else begin
      i_w_enb_r <= 1'b0;
      d_w_enb_r <= 1'b0;
      if (accept) begin
        case (state)
          S_CMD:    target_d <= (bus.in_dat == CMD_D);
          S_LEN_LO: len_lo <= bus.in_dat;
          S_LEN_HI: begin
            // N <= MAX_WORDS, so N-1 always fits the word index width.
            len_m1   <= n_words[WIDX_W-1:0] - WIDX_W'(1);
            word_idx <= '0;
            byte_idx <= 2'd0;
            csum     <= 8'h00;
          end
          S_DATA: begin
            csum     <= csum ^ bus.in_dat;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_sh[7:0]   <= bus.in_dat;
              2'd1: word_sh[15:8]  <= bus.in_dat;
              2'd2: word_sh[23:16] <= bus.in_dat;
              default: begin
                word_idx <= word_idx + WIDX_W'(1);
                if (target_d) begin
                  d_w_enb_r  <= 1'b1;
                  d_w_addr_r <= {word_idx, 2'b00};
                  d_w_dat_r  <= {bus.in_dat, word_sh};
                end else begin
                  i_w_enb_r  <= 1'b1;
                  i_w_addr_r <= {word_idx, 2'b00};
                  i_w_dat_r  <= {bus.in_dat, word_sh};
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.i_w_addr = i_w_addr_r;
  assign bus.i_w_dat  = i_w_dat_r;
  assign bus.i_w_enb  = i_w_enb_r;
  assign bus.d_w_addr = d_w_addr_r;
  assign bus.d_w_dat  = d_w_dat_r;
  assign bus.d_w_enb  = d_w_enb_r;

  assign d_bram_init_done = (state == S_RUN);
  assign pc_stall         = (state != S_RUN);
  assign err              = (state == S_ERROR);
  assign busy             = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                            (state == S_DATA)   || (state == S_CSUM);

endmodule
